// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_buffer
// Ping-pong buffer collecting streamed complex samples into flattened N-point
// frames with frame-level valid/ready hand-off to the butterfly stages.
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_buffer #(
  parameter int N      = 16,
  parameter int WIDTH  = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_re,
  input  logic [WIDTH-1:0]   in_im,
  input  logic               in_last,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [N*WIDTH-1:0] frame_re_flat,
  output logic [N*WIDTH-1:0] frame_im_flat,
  output logic [15:0]        frame_count,
  output logic               err_len,
  input  logic               clear_err
);

  localparam int              LOGN     = $clog2(N);
  localparam logic [LOGN-1:0] LAST_PTR = LOGN'(N - 1);

  logic [N*WIDTH-1:0] bank_re_q [2];
  logic [N*WIDTH-1:0] bank_re_d [2];
  logic [N*WIDTH-1:0] bank_im_q [2];
  logic [N*WIDTH-1:0] bank_im_d [2];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [LOGN-1:0]    wr_ptr_q, wr_ptr_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               err_len_q, err_len_d;
  logic [LOGN-1:0]    wr_slot;
  logic               accept;
  logic               frame_take;
  logic               new_err;

  function automatic logic [LOGN-1:0] bit_reverse(input logic [LOGN-1:0] p);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = p[LOGN-1-i];
    return r;
  endfunction

  assign wr_slot       = BITREV ? bit_reverse(wr_ptr_q) : wr_ptr_q;
  // Handshake outputs come straight from registered flags only.
  assign in_ready      = ~full_q[wr_bank_q];
  assign frame_valid   = full_q[rd_bank_q];
  assign accept        = in_valid & in_ready;
  assign frame_take    = frame_valid & frame_ready;
  assign frame_re_flat = bank_re_q[rd_bank_q];
  assign frame_im_flat = bank_im_q[rd_bank_q];
  assign frame_count   = frame_count_q;
  assign err_len       = err_len_q;

  always_comb begin
    bank_re_d     = bank_re_q;
    bank_im_d     = bank_im_q;
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_ptr_d      = wr_ptr_q;
    frame_count_d = frame_count_q;
    new_err       = 1'b0;

    if (accept) begin
      bank_re_d[wr_bank_q][wr_slot*WIDTH +: WIDTH] = in_re;
      bank_im_d[wr_bank_q][wr_slot*WIDTH +: WIDTH] = in_im;
      if (wr_ptr_q == LAST_PTR) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_ptr_d          = '0;
        new_err           = ~in_last;
      end else if (in_last) begin
        // Short frame: drop it and restart filling the same bank.
        wr_ptr_d = '0;
        new_err  = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // Commit targets an empty bank and release a full one, so never the same.
    if (frame_take) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_count_d     = frame_count_q + 16'd1;
    end

    err_len_d = (err_len_q & ~clear_err) | new_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_re_q     <= '{default: '0};
      bank_im_q     <= '{default: '0};
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      frame_count_q <= 16'd0;
      err_len_q     <= 1'b0;
    end else begin
      bank_re_q     <= bank_re_d;
      bank_im_q     <= bank_im_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_count_q <= frame_count_d;
      err_len_q     <= err_len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_buffer
// Self-checking bench for fft_frame_buffer (natural and bit-reversed builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_buffer;

  localparam int N    = 16;
  localparam int W    = 16;
  localparam int LOGN = 4;
  localparam int NW   = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, frame_ready, clear_err;
  logic [W-1:0]  in_re, in_im;
  logic          in_ready, frame_valid, err_len;
  logic          in_ready_b, frame_valid_b, err_len_b;
  logic [NW-1:0] re_flat, im_flat, re_flat_b, im_flat_b;
  logic [15:0]   frame_count, frame_count_b;

  fft_frame_buffer #(.N(N), .WIDTH(W), .BITREV(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_re_flat(re_flat), .frame_im_flat(im_flat),
    .frame_count(frame_count), .err_len(err_len), .clear_err(clear_err)
  );

  fft_frame_buffer #(.N(N), .WIDTH(W), .BITREV(1'b1)) dut_br (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .frame_valid(frame_valid_b), .frame_ready(frame_ready),
    .frame_re_flat(re_flat_b), .frame_im_flat(im_flat_b),
    .frame_count(frame_count_b), .err_len(err_len_b), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: completed frames waiting for hand-off, in sample order.
  typedef struct packed {
    logic [NW-1:0] re;
    logic [NW-1:0] im;
  } frame_t;

  frame_t        pend[$];
  logic [NW-1:0] cur_re, cur_im;
  int            cur_n;
  int            m_count;
  bit            m_err;
  int            seq;

  typedef struct packed {
    logic        v;
    logic        last;
    logic        fr;
    logic        exp_fv;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[N+1];

  task automatic check_i(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_v(string name, logic [NW-1:0] act, logic [NW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int rev(int k);
    int r = 0;
    for (int i = 0; i < LOGN; i++)
      if (((k >> i) & 1) == 1) r = r | (1 << (LOGN - 1 - i));
    return r;
  endfunction

  // Place sample k of a frame at its storage slot.
  function automatic logic [NW-1:0] pack(logic [NW-1:0] samples, bit br);
    logic [NW-1:0] o = '0;
    for (int k = 0; k < N; k++) begin
      int s = br ? rev(k) : k;
      o[s*W +: W] = samples[k*W +: W];
    end
    return o;
  endfunction

  task automatic compare_model();
    bit has = (pend.size() > 0);
    check_i("in_ready", int'(in_ready), int'(pend.size() < 2));
    check_i("in_ready_br", int'(in_ready_b), int'(pend.size() < 2));
    check_i("frame_valid", int'(frame_valid), int'(has));
    check_i("frame_valid_br", int'(frame_valid_b), int'(has));
    check_i("frame_count", int'(frame_count), m_count & 16'hFFFF);
    check_i("frame_count_br", int'(frame_count_b), m_count & 16'hFFFF);
    check_i("err_len", int'(err_len), int'(m_err));
    if (has) begin
      check_v("re_flat", re_flat, pack(pend[0].re, 1'b0));
      check_v("im_flat", im_flat, pack(pend[0].im, 1'b0));
      check_v("re_flat_br", re_flat_b, pack(pend[0].re, 1'b1));
      check_v("im_flat_br", im_flat_b, pack(pend[0].im, 1'b1));
    end
  endtask

  // One clock: drive inputs, advance the model by the frame rules, compare.
  task automatic step(bit v, bit last, bit fr, bit clr);
    bit     acc, rel, newerr;
    frame_t f;
    in_valid    = v;
    in_re       = W'(seq);
    in_im       = W'(-seq);
    in_last     = last;
    frame_ready = fr;
    clear_err   = clr;
    acc = v && (pend.size() < 2);
    rel = fr && (pend.size() > 0);
    @(posedge clk);
    #1;
    if (rel) begin
      f = pend.pop_front();
      m_count++;
    end
    newerr = 1'b0;
    if (acc) begin
      cur_re[cur_n*W +: W] = in_re;
      cur_im[cur_n*W +: W] = in_im;
      cur_n++;
      if (cur_n == N) begin
        f.re = cur_re;
        f.im = cur_im;
        pend.push_back(f);
        cur_n = 0;
        newerr = !last;
      end else if (last) begin
        cur_n  = 0;
        newerr = 1'b1;
      end
      seq++;
    end
    if (clr) m_err = 1'b0;
    if (newerr) m_err = 1'b1;
    compare_model();
  endtask

  task automatic feed(int n, bit fr);
    for (int i = 0; i < n; i++) step(1'b1, cur_n == N - 1, fr, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b0; clear_err = 1'b0;
    rst = 1'b1;
    #2;
    check_i("rst_in_ready", int'(in_ready), 1);
    check_i("rst_frame_valid", int'(frame_valid), 0);
    check_i("rst_frame_count", int'(frame_count), 0);
    check_i("rst_err_len", int'(err_len), 0);
    check_v("rst_re_flat", re_flat, '0);
    check_v("rst_im_flat_br", im_flat_b, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    cur_n = 0; m_count = 0; m_err = 1'b0; seq = 0;
    cur_re = '0; cur_im = '0;
  endtask

  initial begin
    int n_acc;
    int cyc;
    rst = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b0; clear_err = 1'b0;
    in_re = '0; in_im = '0;
    #1;
    do_reset();

    // Back-to-back frame with frame_ready held high.
    for (int k = 0; k < N; k++)
      vecs[k] = '{v: 1'b1, last: (k == N - 1), fr: 1'b1, exp_fv: (k == N - 1), exp_cnt: 16'd0};
    vecs[N] = '{v: 1'b0, last: 1'b0, fr: 1'b1, exp_fv: 1'b0, exp_cnt: 16'd1};
    for (int i = 0; i <= N; i++) begin
      step(vecs[i].v, vecs[i].last, vecs[i].fr, 1'b0);
      check_i("tbl_frame_valid", int'(frame_valid), int'(vecs[i].exp_fv));
      check_i("tbl_frame_count", int'(frame_count), int'(vecs[i].exp_cnt));
      if (i == N - 1) begin
        for (int k = 0; k < N; k++) begin
          check_i("tbl_slot_re", int'(re_flat[k*W +: W]), k & 16'hFFFF);
          check_i("tbl_slot_im", int'(im_flat[k*W +: W]), (-k) & 16'hFFFF);
        end
        check_i("br_slot1", int'(re_flat_b[1*W +: W]), 8);
        check_i("br_slot3", int'(re_flat_b[3*W +: W]), 12);
        check_i("br_slot15", int'(re_flat_b[15*W +: W]), 15);
      end
    end
    check_i("tbl_err_len", int'(err_len), 0);

    // Backpressure: both banks fill, then one release.
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) n_acc++;
      step(1'b1, cur_n == N - 1, 1'b0, 1'b0);
    end
    check_i("bp_accepts", n_acc, 32);
    check_i("bp_in_ready_low", int'(in_ready), 0);
    step(1'b1, cur_n == N - 1, 1'b1, 1'b0);
    check_i("bp_count", int'(frame_count), 1);
    check_i("bp_in_ready_high", int'(in_ready), 1);
    check_i("bp_second_frame", int'(re_flat[0 +: W]), 16);
    feed(N, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Length errors: early in_last, clear, then missing in_last.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, i == 9, 1'b0, 1'b0);
    check_i("early_last_err", int'(err_len), 1);
    check_i("early_last_no_frame", int'(frame_valid), 0);
    feed(N, 1'b0);
    check_i("resync_slot0", int'(re_flat[0 +: W]), 10);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_i("clear_err", int'(err_len), 0);
    feed(N - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_i("missing_last_err", int'(err_len), 1);
    check_i("missing_last_frame", int'(frame_valid), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    feed(7, 1'b0);
    do_reset();
    feed(N, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_i("post_reset_count", int'(frame_count), 1);

    // Random traffic: 200 frames against the model.
    do_reset();
    cyc = 0;
    while (m_count < 200 && cyc < 40000) begin
      step(($urandom_range(1, 0) == 1) && (seq < 200 * N), cur_n == N - 1,
           $urandom_range(9, 0) < 3, 1'b0);
      cyc++;
    end
    check_i("rand_timeout", int'(cyc < 40000), 1);
    check_i("rand_frame_count", int'(frame_count), 200);
    check_i("rand_err_len", int'(err_len), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised ping-pong frame buffer that turns a streaming complex sample interface (valid/ready) into complete N-point frames, presented flattened to the downstream butterfly stages with a frame-level valid/ready handshake. It replaces single-bank capture-on-request front ends: addressing is internal and write order is optionally bit-reversed. One bank fills while the other is held for the FFT datapath. It sits between the sample source and the stage-1 butterfly network.

## Interface
- N, 16: frame length in complex samples; power of two, 4..256. LOGN = $clog2(N) is derived internally.
- WIDTH, 16: signed width of each real and imaginary sample.
- BITREV, 0: 1 = sample k is stored at slot bitrev(k, LOGN); 0 = natural order.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_re  in  WIDTH  signed real part.
- in_im  in  WIDTH  signed imaginary part.
- in_last  in  1  marks the final sample of a frame (checked only).
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  downstream consumes the presented frame.
- frame_re_flat  out  N*WIDTH  slot s at bits [(s+1)*WIDTH-1 : s*WIDTH].
- frame_im_flat  out  N*WIDTH  same packing, imaginary parts.
- frame_count  out  16  number of frames handed off; wraps 0xFFFF->0.
- err_len  out  1  sticky frame-length error.
- clear_err  in  1  synchronous clear of err_len.

## Operation
- State: two banks (bank 0/1), each N×2×WIDTH; full[1:0]; wr_bank, wr_ptr[LOGN-1:0]; rd_bank.
- in_ready = !full[wr_bank]. An accept is in_valid && in_ready.
- On accept, the sample is written to bank[wr_bank] at slot wr_ptr (or bitrev(wr_ptr) when BITREV=1), then wr_ptr increments.
- On accept with wr_ptr==N-1: set full[wr_bank], toggle wr_bank, wr_ptr<=0. If in_last=0 on this sample, set err_len; the frame is still committed.
- On accept with in_last=1 and wr_ptr!=N-1: set err_len, wr_ptr<=0, bank not marked full, partial frame discarded, wr_bank unchanged.
- frame_valid = full[rd_bank]. frame_*_flat is muxed from bank[rd_bank] and is stable while frame_valid=1.
- On frame_valid && frame_ready: clear full[rd_bank], toggle rd_bank, frame_count+1.
- Simultaneous commit on one bank and release on the other: both take effect on the same edge.
- clear_err clears err_len. If a new error occurs in the same cycle, the error wins and err_len stays 1.
- Only the top-bit-free wr_ptr is used, so wrap-around is implicit modulo N.

## Timing
- Reset (async, any time, including mid-frame): all banks 0, full=00, wr_bank=rd_bank=0, wr_ptr=0. Outputs: in_ready=1, frame_valid=0, flat outputs 0, frame_count=0, err_len=0. Partial frames are lost.
- Latency: Nth sample accepted at edge k, frame_valid=1 in the cycle after edge k.
- Throughput: one sample/cycle sustained when frame_ready is held at 1. There are no bubbles at frame boundaries.
- in_ready depends on registered full flags only, with no combinational path from frame_ready. With both banks full, in_ready rises the cycle after the release edge.
- frame_valid has no combinational dependency on in_valid.

## Test plan
- N=16, BITREV=0, in_re=k, in_im=-k for k=0..15 back-to-back, frame_ready=1 -> frame_valid high 1 cycle after the 16th accept; slot k re=k, im=-k; frame_count=1; err_len=0.
- BITREV=1, same stimulus -> slot 1 holds 8, slot 3 holds 12, slot 15 holds 15; slot s holds bitrev(s).
- frame_ready=0, in_valid held for 40 samples -> exactly 32 accepts, then in_ready=0. frame_ready pulsed 1 cycle -> frame_count=1; in_ready=1 next cycle; the second frame is presented (samples 16..31); bank 0 refills with samples 32..
- in_last on the 10th sample -> err_len=1, no frame_valid; the next 16 samples form a frame with slot 0 = sample 11. clear_err -> err_len=0. A missing in_last on sample 16 -> err_len=1 and the frame is still delivered.
- rst asserted after 7 accepts -> all outputs at reset values immediately; the next 16 samples yield a correct frame with frame_count=1.
- in_valid random 50% duty, frame_ready random 30% duty, 200 frames -> every frame matches the model, no loss or duplication, frame_count=200.
